execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock for the EX/MEM pipeline register.
REQ-002 SHALL have rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE, inputs, 1 bit each: control from the ID/EX register.
REQ-004 SHALL have ALUControlE, input, 3 bits: ALU operation select.
REQ-005 SHALL have RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlusE, inputs, 32 bits each: operands, immediate, PC, PC+4.
REQ-006 SHALL have RD_E, input, 5 bits: destination register.
REQ-007 SHALL have ForwardAE, ForwardBE, inputs, 2 bits each: operand-forwarding selects from the hazard unit.
REQ-008 SHALL have ResultW, input, 32 bits: writeback-stage result used for forwarding.
REQ-009 SHALL have StallM and FlushM, inputs, 1 bit each: hold and bubble-insert for the EX/MEM register.
REQ-010 SHALL have PCSrcE, output, 1 bit, and PCTargetE, output, 32 bits: combinational branch decision and target.
REQ-011 SHALL have RegWriteM, MemWriteM, ResultSrcM, outputs, 1 bit each; RD_M, output, 5 bits; ALUResultM, WriteDataM, PCPlusM, outputs, 32 bits each: registered EX/MEM contents.

Function
REQ-012 SHALL select SrcAE by ForwardAE: 00 RD1_E, 01 ResultW, 10 ALUResultM, 11 RD1_E.
REQ-013 SHALL select the forwarded B operand by ForwardBE with the same encoding on RD2_E; that value SHALL be WriteDataE.
REQ-014 SHALL use SrcBE = Imm_Ext_E when ALU_SrcE=1, else the forwarded B operand.
REQ-015 SHALL compute the ALU result per ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (result 0 or 1); 100, 110, 111 SHALL yield 0.
REQ-016 SHALL perform add/sub modulo 2^32; overflow SHALL be ignored, and slt SHALL use the correct signed comparison even when the subtraction overflows.
REQ-017 SHALL assert ZeroE when the 32-bit ALU result equals 0.
REQ-018 SHALL drive PCSrcE = BranchE AND ZeroE, combinationally in the same cycle.
REQ-019 SHALL drive PCTargetE = PCE + Imm_Ext_E modulo 2^32, combinationally.
REQ-020 SHALL capture, on each rising edge with FlushM=0 and StallM=0: RegWriteE, MemWriteE, ResultSrcE, RD_E, the ALU result, WriteDataE and PCPlusE into the *M outputs. Latency is 1 cycle.
REQ-021 SHALL hold every *M output unchanged on an edge with StallM=1 and FlushM=0.
REQ-022 SHALL, on an edge with FlushM=1, clear RegWriteM and MemWriteM to 0, and SHALL then capture or hold the remaining outputs as if FlushM=0; flush SHALL take priority over stall.
REQ-023 SHALL forward with ForwardAE/BE=10 the pre-edge value of ALUResultM, i.e. the result of the previous instruction.

Reset
REQ-024 SHALL, while rst=0, asynchronously force RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM and PCPlusM to 0.
REQ-025 SHALL resume capture on the first rising edge after rst deasserts; a reset mid-stream SHALL drop the in-flight instruction without generating a write.

Structure
REQ-026 SHALL take the ALU opcode constants (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101) and the forward-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10) from a shared package, riscv_pkg.
REQ-027 SHALL instantiate the ALU as one sub-module, alu (inputs A, B, ALUControl; outputs Result, Zero), and SHALL implement the forwarding muxes, adder and register inline.

Verification
REQ-028 Reset: rst=0 while inputs are nonzero -> all *M outputs are 0 immediately; after release, the first edge captures the inputs.
REQ-029 Add/slt: RD1_E=5, RD2_E=7, ALUControlE=000 -> ALUResultM=12 after 1 edge; RD1_E=0x80000000, RD2_E=1, ALUControlE=101 -> ALUResultM=1.
REQ-030 Branch: BranchE=1, RD1_E=RD2_E=0x1234, ALUControlE=001, PCE=0x100, Imm_Ext_E=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle; RD2_E=0x1235 -> PCSrcE=0.
REQ-031 Forwarding: ALUResultM=0xAA, ResultW=0xBB, ForwardAE=10, ForwardBE=01, ALUControlE=000 -> next ALUResultM=0x165 and WriteDataM=0xBB.
REQ-032 Stall/flush: StallM=1 -> outputs hold across 3 edges; StallM=1 with FlushM=1 and RegWriteM=1 -> RegWriteM=0 and MemWriteM=0 after the edge.
REQ-033 Immediate and wrap: ALU_SrcE=1, RD1_E=0xFFFFFFFF, Imm_Ext_E=1, ALUControlE=000 -> ALUResultM=0, and WriteDataM=RD2_E.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcodes, forwarding selects and the
// EX/MEM register layout used by the execute stage.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus;
    } exmem_t;

    // Select 11 is unused by the hazard unit and falls back to the register file.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf_val,
                                            input logic [31:0] wb_val,
                                            input logic [31:0] mem_val);
        logic [31:0] y;
        case (sel)
            FWD_WB:  y = wb_val;
            FWD_MEM: y = mem_val;
            default: y = rf_val;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU: add, sub, and, or, signed set-less-than; other codes give 0.
module alu
    import riscv_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    always_comb begin
        Result = 32'd0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            // Direct signed compare, so a wrapping A-B cannot flip the answer.
            ALU_SLT: Result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            default: Result = 32'd0;
        endcase
    end

    assign Zero = (Result == 32'd0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch decision/target, and the
// EX/MEM pipeline register with stall (hold) and flush (drop writes).
module execute_cycle
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALU_SrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlusE,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlusM
);

    exmem_t      exmem_d, exmem_q;
    logic [31:0] src_a_e, src_b_e, write_data_e, alu_result_e;
    logic        zero_e;

    // MEM forwarding uses the registered result, i.e. the previous instruction.
    assign src_a_e      = fwd_mux(ForwardAE, RD1_E, ResultW, exmem_q.alu_result);
    assign write_data_e = fwd_mux(ForwardBE, RD2_E, ResultW, exmem_q.alu_result);
    assign src_b_e      = ALU_SrcE ? Imm_Ext_E : write_data_e;

    alu u_alu (
        .A          (src_a_e),
        .B          (src_b_e),
        .ALUControl (ALUControlE),
        .Result     (alu_result_e),
        .Zero       (zero_e)
    );

    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Flush overrides stall only for the write enables; the payload still
    // follows the stall/capture rule.
    always_comb begin
        exmem_d = exmem_q;
        if (!StallM) begin
            exmem_d.reg_write  = RegWriteE;
            exmem_d.mem_write  = MemWriteE;
            exmem_d.result_src = ResultSrcE;
            exmem_d.rd         = RD_E;
            exmem_d.alu_result = alu_result_e;
            exmem_d.write_data = write_data_e;
            exmem_d.pc_plus    = PCPlusE;
        end
        if (FlushM) begin
            exmem_d.reg_write = 1'b0;
            exmem_d.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign RegWriteM  = exmem_q.reg_write;
    assign MemWriteM  = exmem_q.mem_write;
    assign ResultSrcM = exmem_q.result_src;
    assign RD_M       = exmem_q.rd;
    assign ALUResultM = exmem_q.alu_result;
    assign WriteDataM = exmem_q.write_data;
    assign PCPlusM    = exmem_q.pc_plus;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed scenarios plus randomized cycles checked
// against a behavioural model of the execute stage and EX/MEM register.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlusE, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallM, FlushM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlusM;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the EX/MEM register contents.
    logic        m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pcp;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALU_SrcE(ALU_SrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlusE(PCPlusE), .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlusM(PCPlusM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0:    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            3'd1:    return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return rf;
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pcp = 0;
    endtask

    task automatic check_m(input string pfx);
        chk({pfx, "_regwrite"}, 32'(RegWriteM), 32'(m_rw));
        chk({pfx, "_memwrite"}, 32'(MemWriteM), 32'(m_mw));
        chk({pfx, "_resultsrc"}, 32'(ResultSrcM), 32'(m_rs));
        chk({pfx, "_rd"}, 32'(RD_M), 32'(m_rd));
        chk({pfx, "_aluresult"}, ALUResultM, m_alu);
        chk({pfx, "_writedata"}, WriteDataM, m_wd);
        chk({pfx, "_pcplus"}, PCPlusM, m_pcp);
    endtask

    task automatic set_idle();
        RegWriteE = 0; ALU_SrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlusE = 0;
        RD_E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0; StallM = 0; FlushM = 0;
    endtask

    task automatic drive_random();
        RegWriteE  = 1'($urandom); ALU_SrcE = 1'($urandom); MemWriteE = 1'($urandom);
        ResultSrcE = 1'($urandom); BranchE  = 1'($urandom);
        ALUControlE = 3'($urandom_range(0, 7));
        RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom;
        PCE = $urandom; PCPlusE = $urandom; ResultW = $urandom;
        RD_E = 5'($urandom);
        ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
        StallM = ($urandom_range(0, 5) == 0);
        FlushM = ($urandom_range(0, 6) == 0);
    endtask

    // Check the combinational outputs, advance one edge, check the register.
    task automatic step(input string pfx);
        logic [31:0] a, wd, b, res;
        #1;
        a   = ref_fwd(ForwardAE, RD1_E);
        wd  = ref_fwd(ForwardBE, RD2_E);
        b   = ALU_SrcE ? Imm_Ext_E : wd;
        res = ref_alu(ALUControlE, a, b);
        chk({pfx, "_pcsrc"}, 32'(PCSrcE), 32'(BranchE && (res == 0)));
        chk({pfx, "_pctarget"}, PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        if (!StallM) begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RD_E;
            m_alu = res; m_wd = wd; m_pcp = PCPlusE;
        end
        if (FlushM) begin
            m_rw = 0; m_mw = 0;
        end
        #1;
        check_m(pfx);
    endtask

    initial begin
        // Reset held with nonzero inputs: outputs must already be zero.
        drive_random();
        StallM = 0; FlushM = 0;
        model_reset();
        #3;
        check_m("reset");
        @(posedge clk);
        #2;
        check_m("reset_hold");
        rst = 1'b1;
        step("post_reset");

        set_idle();
        RD1_E = 32'd5; RD2_E = 32'd7; ALUControlE = 3'b000;
        step("add");
        chk("add_value", ALUResultM, 32'd12);

        RD1_E = 32'h8000_0000; RD2_E = 32'd1; ALUControlE = 3'b101;
        step("slt");
        chk("slt_value", ALUResultM, 32'd1);

        BranchE = 1; RD1_E = 32'h1234; RD2_E = 32'h1234; ALUControlE = 3'b001;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        chk("branch_taken", 32'(PCSrcE), 32'd1);
        chk("branch_target", PCTargetE, 32'h120);
        RD2_E = 32'h1235;
        #1;
        chk("branch_not_taken", 32'(PCSrcE), 32'd0);
        step("branch");

        set_idle();
        RD1_E = 32'hAA; ALUControlE = 3'b000;
        step("fwd_setup");
        ResultW = 32'hBB; ForwardAE = 2'b10; ForwardBE = 2'b01; RD1_E = 32'h1; RD2_E = 32'h2;
        step("fwd");
        chk("fwd_alu", ALUResultM, 32'h165);
        chk("fwd_wd", WriteDataM, 32'hBB);

        set_idle();
        RegWriteE = 1; MemWriteE = 1; RD1_E = 32'h33; RD_E = 5'd9; PCPlusE = 32'h44;
        step("stall_setup");
        StallM = 1; RD1_E = 32'h99; RD_E = 5'd3; PCPlusE = 32'h88;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_alu", ALUResultM, 32'h33);
        FlushM = 1;
        step("stall_flush");
        chk("stall_flush_rw", 32'(RegWriteM), 32'd0);
        chk("stall_flush_mw", 32'(MemWriteM), 32'd0);

        set_idle();
        ALU_SrcE = 1; RD1_E = 32'hFFFF_FFFF; Imm_Ext_E = 32'd1; RD2_E = 32'h5A5A;
        step("imm_wrap");
        chk("imm_wrap_alu", ALUResultM, 32'd0);
        chk("imm_wrap_wd", WriteDataM, 32'h5A5A);

        // Mid-stream reset drops the in-flight write.
        RegWriteE = 1; MemWriteE = 1;
        step("pre_midreset");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_m("midreset");
        @(posedge clk);
        #2;
        check_m("midreset_hold");
        rst = 1'b1;
        step("after_midreset");

        for (int i = 0; i < 400; i++) begin
            drive_random();
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
